// File: rtl/cpu_defs_pkg.sv
// cpu_defs: memory-command encodings and I/O addresses shared with the control FSM
package cpu_defs;
  localparam logic [1:0] MNONE = 2'b00;
  localparam logic [1:0] MWRITE = 2'b01;
  localparam logic [1:0] MREAD = 2'b10;
  localparam logic [8:0] LED_ADDR = 9'h100;
  localparam logic [8:0] SW_ADDR = 9'h140;
endpackage

// File: rtl/sync2.sv
// sync2: parameterised-width two-flop synchronizer
module sync2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  // two flops back to back to settle metastability
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      meta <= '0;
      q <= '0;
    end else begin
      meta <= d;
      q <= meta;
    end
endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: steers CPU memory commands to RAM, LED register and switch port
module mem_bus_ctrl import cpu_defs::*; #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int RAM_LAT = 1,
  parameter logic [ADDR_W-1:0] LED_ADDR = cpu_defs::LED_ADDR,
  parameter logic [ADDR_W-1:0] SW_ADDR = cpu_defs::SW_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_ready,
  output logic              bus_err,
  output logic [ADDR_W-2:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic [7:0]        sw_in,
  output logic [7:0]        led_out
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, HOLD, WR} state_t;
  state_t state, state_n;
  logic [1:0] cnt, cnt_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] read_data_n;
  logic ready_n, err_n, start, is_ram, is_led, is_sw;
  logic [7:0] led_n, sw_sync;
  sync2 #(.W(8)) u_sw_sync (.clk(clk), .reset(reset), .d(sw_in), .q(sw_sync));
  assign ram_addr = mem_addr[ADDR_W-2:0];
  assign ram_din = write_data;
  assign is_ram = ~mem_addr[ADDR_W-1];
  assign is_led = mem_addr == LED_ADDR;
  assign is_sw = mem_addr == SW_ADDR;
  assign start = state == IDLE || (state == HOLD && mem_cmd == MREAD && mem_addr != addr_q);
  // state register and registered bus outputs
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      read_data <= '0;
      mem_ready <= 1'b0;
      bus_err <= 1'b0;
      led_out <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      addr_q <= addr_n;
      read_data <= read_data_n;
      mem_ready <= ready_n;
      bus_err <= err_n;
      led_out <= led_n;
    end
  // next state: hold/abort handling first, then a fresh decode when an access starts
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    addr_n = addr_q;
    read_data_n = read_data;
    ready_n = 1'b0;
    err_n = bus_err;
    led_n = led_out;
    ram_write = 1'b0;
    case (state)
      RD_WAIT:
        if (mem_cmd != MREAD || mem_addr != addr_q) state_n = IDLE;
        else if (cnt == 2'd1) begin
          read_data_n = ram_dout;
          ready_n = 1'b1;
          state_n = HOLD;
        end else cnt_n = cnt - 2'd1;
      HOLD: state_n = mem_cmd == MREAD ? HOLD : IDLE;
      WR: state_n = mem_cmd == MWRITE ? WR : IDLE;
      default: ;
    endcase
    if (start) begin
      addr_n = mem_addr;
      if (mem_cmd == MREAD && is_ram) begin
        cnt_n = 2'(RAM_LAT);
        state_n = RD_WAIT;
      end else if (mem_cmd == MREAD && is_sw) begin
        read_data_n = {{(DATA_W-8){1'b0}}, sw_sync};
        ready_n = 1'b1;
        state_n = HOLD;
      end else if (mem_cmd == MWRITE && is_ram) begin
        ram_write = reset;
        ready_n = 1'b1;
        state_n = WR;
      end else if (mem_cmd == MWRITE && is_led) begin
        led_n = write_data[7:0];
        ready_n = 1'b1;
        state_n = WR;
      end else if (mem_cmd != MNONE) begin
        err_n = 1'b1;
        ready_n = 1'b1;
        state_n = mem_cmd == MWRITE ? WR : HOLD;
      end else state_n = IDLE;
    end
  end
endmodule
